// File: rtl/cpld_ram_xbank_if.sv
// Z80 bus inputs and SRAM-side outputs of the CPC RAM-expansion CPLD.
// master = CPU/board side, slave = the expansion controller.
interface cpld_ram_xbank_if #(
    parameter int BANK_BITS = 3
);
    localparam int EXT_W = (BANK_BITS > 3) ? BANK_BITS - 3 : 1;

    logic                 iorq_b;
    logic                 mreq_b;
    logic                 rfsh_b;
    logic                 wr_b;
    logic                 ramrd_b;
    logic                 adr15;
    logic                 adr14;
    logic [EXT_W-1:0]     adr_ext;
    logic [7:0]           data;
    logic                 ramdis;
    logic                 ramcs_b;
    logic                 ramoe_b;
    logic                 ramwe_b;
    logic [BANK_BITS+1:0] ramadrhi;
    logic [BANK_BITS+2:0] cfg_q;
    logic                 mwr_cyc;

    modport master (
        output iorq_b, mreq_b, rfsh_b, wr_b, ramrd_b, adr15, adr14, adr_ext, data,
        input  ramdis, ramcs_b, ramoe_b, ramwe_b, ramadrhi, cfg_q, mwr_cyc
    );

    modport slave (
        input  iorq_b, mreq_b, rfsh_b, wr_b, ramrd_b, adr15, adr14, adr_ext, data,
        output ramdis, ramcs_b, ramoe_b, ramwe_b, ramadrhi, cfg_q, mwr_cyc
    );
endinterface

// File: rtl/cpld_ram_xbank.sv
// CPC RAM-expansion controller (512K..4MB): config-port decode, memory-cycle FSM, SRAM strobes.
// Optional macro SHADOW_MODE_EN routes every non-expansion access to SRAM bank SHADOW_BANK.
module cpld_ram_xbank #(
    parameter int                   BANK_BITS   = 3,
    parameter logic [BANK_BITS-1:0] SHADOW_BANK = {BANK_BITS{1'b1}},
    parameter int                   IOWR_FILTER = 2
) (
    input  logic             clk,
    input  logic             reset_b,
    cpld_ram_xbank_if.slave  bus
);
    localparam int         CFG_W = BANK_BITS + 3;
    localparam logic [1:0] FILT  = 2'(IOWR_FILTER);

    typedef enum logic [1:0] {S_IDLE, S_ACT, S_WR, S_RFSH} state_t;

    state_t               state_q, state_d;
    logic [CFG_W-1:0]     cfg_q, cfg_d, cfg_new;
    logic [1:0]           cnt_q, cnt_d, cnt_inc;
    logic                 armed_q, armed_d;
    logic                 io_hit, load;

    logic [1:0]           blk, block;
    logic [2:0]           mode;
    logic [BANK_BITS-1:0] bank, bank_sel;
    logic                 exp_hit, target, cs_b;

    generate
        if (BANK_BITS > 3) begin : g_ext
            assign cfg_new = {bus.adr_ext, bus.data[5:0]};
        end else begin : g_noext
            logic unused_ext;
            assign unused_ext = ^bus.adr_ext;
            assign cfg_new    = bus.data[5:0];
        end
    endgenerate

    // Write filter: the count saturates at FILT; armed limits loads to one per I/O cycle
    always_comb begin
        io_hit  = !bus.iorq_b && !bus.wr_b && !bus.adr15 && (bus.data[7:6] == 2'b11);
        cnt_inc = (cnt_q == FILT) ? cnt_q : cnt_q + 2'd1;
        cnt_d   = io_hit ? cnt_inc : 2'd0;
        load    = io_hit && armed_q && (cnt_inc == FILT);
        cfg_d   = load ? cfg_new : cfg_q;
        armed_d = bus.iorq_b ? 1'b1 : (load ? 1'b0 : armed_q);
    end

    always_comb begin
        state_d = state_q;
        if (bus.mreq_b) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!bus.rfsh_b)    state_d = S_RFSH;
                    else if (!bus.wr_b) state_d = S_WR;
                    else                state_d = S_ACT;
                end
                S_ACT:   if (!bus.wr_b) state_d = S_WR;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        blk     = {bus.adr15, bus.adr14};
        mode    = cfg_q[2:0];
        bank    = cfg_q[CFG_W-1:3];
        exp_hit = 1'b0;
        block   = blk;
        casez (mode)
            3'b001: begin
                exp_hit = (blk == 2'd3);
                block   = 2'd3;
            end
            3'b010: exp_hit = 1'b1;
            3'b011: begin
                // blk1 maps to block 3 too, but only as a shadow access
                exp_hit = (blk == 2'd3);
                if (blk == 2'd3 || blk == 2'd1) block = 2'd3;
            end
            3'b1??: begin
                exp_hit = (blk == 2'd1);
                block   = mode[1:0];
            end
            default: exp_hit = 1'b0;
        endcase
`ifdef SHADOW_MODE_EN
        target = exp_hit || bus.rfsh_b;
        if (!exp_hit)                 bank_sel = SHADOW_BANK;
        else if (bank == SHADOW_BANK) bank_sel = {SHADOW_BANK[BANK_BITS-1:1], 1'b0};
        else                          bank_sel = bank;
`else
        target   = exp_hit;
        bank_sel = bank;
`endif
        cs_b = bus.mreq_b || !bus.rfsh_b || !target;
    end

`ifndef SHADOW_MODE_EN
    logic [BANK_BITS-1:0] unused_shadow;
    assign unused_shadow = SHADOW_BANK;
`endif

    assign bus.ramcs_b  = cs_b;
    assign bus.ramdis   = target && !bus.mreq_b && bus.rfsh_b;
    assign bus.ramwe_b  = (state_q != S_WR) || cs_b;
    assign bus.ramoe_b  = bus.ramrd_b;
    assign bus.ramadrhi = target ? {bank_sel, block} : '0;
    assign bus.cfg_q    = cfg_q;
    assign bus.mwr_cyc  = (state_q == S_WR);

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_q <= S_IDLE;
            cfg_q   <= '0;
            cnt_q   <= '0;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end
endmodule

// File: tb/tb_cpld_ram_xbank.sv
// Bench for cpld_ram_xbank (BANK_BITS=5, IOWR_FILTER=2): directed steps then random bus traffic
// checked every clock against a cycle-level model of the config port and memory cycles.
module tb_cpld_ram_xbank;
    localparam int         BB = 5;
    localparam logic [4:0] SH = 5'h1F;

    logic clk;
    logic reset_b;
    int   n_assert = 0;
    int   n_fail   = 0;

    cpld_ram_xbank_if #(.BANK_BITS(BB)) bus ();

    cpld_ram_xbank #(.BANK_BITS(BB), .IOWR_FILTER(2)) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model state: config word, consecutive-hit count, one-load-per-cycle flag,
    // and per-memory-cycle flags (in cycle / refresh cycle / write strobe phase)
    logic [7:0] m_cfg;
    int         m_cnt;
    bit         m_armed, m_cyc, m_rf, m_wr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_update();
        bit hit, load;
        if (!reset_b) begin
            m_cfg = 8'h00; m_cnt = 0; m_armed = 1'b1;
            m_cyc = 1'b0; m_rf = 1'b0; m_wr = 1'b0;
        end else begin
            hit   = !bus.iorq_b && !bus.wr_b && !bus.adr15 && bus.data[7] && bus.data[6];
            m_cnt = hit ? m_cnt + 1 : 0;
            load  = hit && m_armed && (m_cnt >= 2);
            if (load) m_cfg = {bus.adr_ext, bus.data[5:0]};
            if (bus.iorq_b) m_armed = 1'b1;
            else if (load)  m_armed = 1'b0;
            if (bus.mreq_b) begin
                m_cyc = 1'b0; m_rf = 1'b0; m_wr = 1'b0;
            end else if (!m_cyc) begin
                m_cyc = 1'b1;
                m_rf  = !bus.rfsh_b;
                m_wr  = bus.rfsh_b && !bus.wr_b;
            end else if (!m_rf && !bus.wr_b) begin
                m_wr = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        logic [4:0] bank, bank_out;
        logic [2:0] mode;
        int         blk, blk_out;
        bit         exp_hit, target, e_cs;
        bank    = m_cfg[7:3];
        mode    = m_cfg[2:0];
        blk     = {bus.adr15, bus.adr14};
        exp_hit = 1'b0;
        blk_out = blk;
        if (mode == 3'd1 && blk == 3) begin exp_hit = 1'b1; blk_out = 3; end
        if (mode == 3'd2) exp_hit = 1'b1;
        if (mode == 3'd3 && blk == 3) begin exp_hit = 1'b1; blk_out = 3; end
        if (mode == 3'd3 && blk == 1) blk_out = 3;
        if (mode >= 3'd4 && blk == 1) begin exp_hit = 1'b1; blk_out = mode % 4; end
`ifdef SHADOW_MODE_EN
        target   = exp_hit || bus.rfsh_b;
        bank_out = !exp_hit ? SH : (bank == SH ? SH - 5'd1 : bank);
`else
        target   = exp_hit;
        bank_out = bank;
`endif
        e_cs = bus.mreq_b || !bus.rfsh_b || !target;
        chk("cfg_q",    bus.cfg_q,    m_cfg);
        chk("ramcs_b",  bus.ramcs_b,  e_cs);
        chk("ramdis",   bus.ramdis,   target && !bus.mreq_b && bus.rfsh_b);
        chk("ramwe_b",  bus.ramwe_b,  !(m_wr && !e_cs));
        chk("ramoe_b",  bus.ramoe_b,  bus.ramrd_b);
        chk("mwr_cyc",  bus.mwr_cyc,  m_wr);
        chk("ramadrhi", bus.ramadrhi, target ? 32'(bank_out * 4 + blk_out) : 32'd0);
    endtask

    // Inputs change on the falling edge; outputs checked 1ns later, model steps on the rising edge
    task automatic tick(input bit do_chk);
        #1;
        if (do_chk) check_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_bus();
        bus.iorq_b = 1'b1; bus.mreq_b = 1'b1; bus.rfsh_b = 1'b1; bus.wr_b = 1'b1;
        bus.ramrd_b = 1'b1; bus.adr15 = 1'b0; bus.adr14 = 1'b0;
        bus.adr_ext = 2'b00; bus.data = 8'h00;
    endtask

    task automatic io_write(input logic [1:0] ext, input logic [7:0] d,
                            input logic a15, input int hold);
        bus.adr_ext = ext; bus.data = d; bus.adr15 = a15;
        bus.iorq_b = 1'b0; bus.wr_b = 1'b0;
        for (int i = 0; i < hold; i++) tick(1);
        idle_bus();
        tick(1);
    endtask

    task automatic mem_cycle(input logic a15, input logic a14, input bit wr,
                             input bit rf, input int len);
        bus.adr15 = a15; bus.adr14 = a14; bus.mreq_b = 1'b0;
        bus.rfsh_b = !rf; bus.ramrd_b = wr || rf;
        for (int i = 0; i < len; i++) begin
            bus.wr_b = !(wr && !rf && i > 0);
            tick(1);
        end
        idle_bus();
        tick(1);
    endtask

    initial begin
        int kind, hold;
        logic [7:0] d;
        logic [1:0] ext;

        idle_bus();
        reset_b = 1'b0;
        @(negedge clk);
        tick(0);
        tick(1);
        chk("rst_cfg_q",   bus.cfg_q,    0);
        chk("rst_ramcs_b", bus.ramcs_b,  1);
        chk("rst_ramwe_b", bus.ramwe_b,  1);
        chk("rst_ramdis",  bus.ramdis,   0);
        chk("rst_mwr_cyc", bus.mwr_cyc,  0);
        chk("rst_adrhi",   bus.ramadrhi, 0);
        reset_b = 1'b1;
        tick(1);

        // OUT &7F00,&C2 then memory write to 0x0123 (bank 0 block 0)
        io_write(2'b00, 8'hC2, 1'b0, 2);
        chk("t1_cfg", bus.cfg_q, 8'h02);
        bus.mreq_b = 1'b0; bus.adr15 = 1'b0; bus.adr14 = 1'b0;
        tick(1);
        chk("t1_we_before_wr", bus.ramwe_b, 1);
        bus.wr_b = 1'b0;
        tick(1);
        #1;
        chk("t1_mwr_cyc", bus.mwr_cyc, 1);
        chk("t1_ramwe_b", bus.ramwe_b, 0);
        chk("t1_ramcs_b", bus.ramcs_b, 0);
        chk("t1_adrhi",   bus.ramadrhi, 0);
        idle_bus();
        tick(1);
        chk("t1_we_after", bus.ramwe_b, 1);

        // Short pulse ignored; a long one loads once, at its second clock
        io_write(2'b00, 8'hC5, 1'b0, 1);
        chk("t2_short", bus.cfg_q, 8'h02);
        bus.data = 8'hC7; bus.iorq_b = 1'b0; bus.wr_b = 1'b0;
        tick(1); tick(1);
        bus.data = 8'hC1;
        tick(1); tick(1);
        idle_bus();
        tick(1);
        chk("t2_one_load", bus.cfg_q, 8'h07);
        io_write(2'b00, 8'hC1, 1'b1, 3);
        chk("t2_a15_high", bus.cfg_q, 8'h07);

        // Extended bank bits: OUT &7D00,&CF then read 0x4000
        io_write(2'b01, 8'hCF, 1'b0, 2);
        chk("t3_cfg", bus.cfg_q, 8'h4F);
        bus.mreq_b = 1'b0; bus.adr14 = 1'b1; bus.ramrd_b = 1'b0;
        #1;
        chk("t3_adrhi",  bus.ramadrhi, 7'b0100111);
        chk("t3_ramdis", bus.ramdis, 1);
        chk("t3_ramoe",  bus.ramoe_b, 0);
        tick(1);
        idle_bus();
        tick(1);

        // Refresh in mode 010 never selects SRAM nor reaches the write state
        io_write(2'b00, 8'hC2, 1'b0, 2);
        bus.mreq_b = 1'b0; bus.rfsh_b = 1'b0;
        tick(1);
        bus.wr_b = 1'b0;
        tick(1);
        #1;
        chk("t4_mwr_cyc", bus.mwr_cyc, 0);
        chk("t4_ramcs_b", bus.ramcs_b, 1);
        chk("t4_ramdis",  bus.ramdis, 0);
        idle_bus();
        tick(1);

        // Reset while in the write state
        bus.mreq_b = 1'b0; bus.adr14 = 1'b1;
        tick(1);
        bus.wr_b = 1'b0;
        tick(1);
        chk("t5_in_wr", bus.mwr_cyc, 1);
        reset_b = 1'b0;
        tick(0);
        #1;
        chk("t5_mwr_cyc", bus.mwr_cyc, 0);
        chk("t5_ramwe_b", bus.ramwe_b, 1);
        chk("t5_cfg",     bus.cfg_q, 0);
        reset_b = 1'b1;
        idle_bus();
        tick(1);

        // Mode 011, read 0x4000: shadow block 3 or internal RAM
        io_write(2'b00, 8'hC3, 1'b0, 2);
        bus.mreq_b = 1'b0; bus.adr14 = 1'b1;
        #1;
`ifdef SHADOW_MODE_EN
        chk("t6_adrhi",  bus.ramadrhi, {SH, 2'b11});
        chk("t6_ramdis", bus.ramdis, 1);
`else
        chk("t6_ramcs_b", bus.ramcs_b, 1);
        chk("t6_ramdis",  bus.ramdis, 0);
`endif
        tick(1);
        idle_bus();
        tick(1);

        // Config change inside a memory cycle redirects the in-flight decode
        io_write(2'b00, 8'hC0, 1'b0, 2);
        bus.mreq_b = 1'b0; bus.adr15 = 1'b1; bus.adr14 = 1'b1;
        tick(1);
        bus.data = 8'hD9; bus.adr_ext = 2'b10;
        bus.iorq_b = 1'b0; bus.wr_b = 1'b0; bus.adr15 = 1'b0;
        tick(1); tick(1);
        bus.iorq_b = 1'b1; bus.wr_b = 1'b1; bus.adr15 = 1'b1;
        #1;
        chk("mid_cfg",   bus.cfg_q, 8'h99);
        chk("mid_cs",    bus.ramcs_b, 0);
        chk("mid_adrhi", bus.ramadrhi, 7'b1001111);
        tick(1);
        idle_bus();
        tick(1);

        for (int t = 0; t < 250; t++) begin
            kind = $urandom_range(0, 9);
            if (kind < 3) begin
                hold = $urandom_range(1, 4);
                ext  = 2'($urandom);
                d    = 8'($urandom);
                if ($urandom_range(0, 3) != 0) d[7:6] = 2'b11;
                io_write(ext, d, 1'($urandom_range(0, 4) == 0), hold);
                $display("txn %0d: io ext=%0d data=%02h hold=%0d cfg_q=%02h",
                         t, ext, d, hold, bus.cfg_q);
            end else if (kind < 9) begin
                hold = $urandom_range(1, 4);
                mem_cycle(1'($urandom), 1'($urandom), 1'($urandom),
                          $urandom_range(0, 4) == 0, hold);
                $display("txn %0d: mem len=%0d cfg_q=%02h", t, hold, bus.cfg_q);
            end else begin
                reset_b = 1'b0;
                tick(1);
                reset_b = 1'b1;
                $display("txn %0d: reset cfg_q=%02h", t, bus.cfg_q);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
